// File: rtl/bf16_pkg.sv
// Shared bfloat16 element type, field constants and classification helpers
// for the power-of-two scaling pipeline.
package bf16_pkg;

  localparam int unsigned BF_EXP_W = 8;
  localparam int unsigned BF_MAN_W = 7;
  localparam int unsigned BF_W     = 1 + BF_EXP_W + BF_MAN_W;

  typedef struct packed {
    logic                sign;
    logic [BF_EXP_W-1:0] exp;
    logic [BF_MAN_W-1:0] man;
  } bf16_t;

  localparam int unsigned         EXP_BIAS     = (1 << (BF_EXP_W - 1)) - 1;
  localparam logic [BF_EXP_W-1:0] EXP_ALL_ONES = BF_EXP_W'(2 * EXP_BIAS + 1);
  localparam bf16_t               POS_INF      = '{sign: 1'b0, exp: EXP_ALL_ONES, man: '0};
  localparam bf16_t               NEG_INF      = '{sign: 1'b1, exp: EXP_ALL_ONES, man: '0};

  // Zero and denormal inputs share a class: denormals are flushed on entry.
  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_SPECIAL
  } lane_class_t;

  function automatic logic is_special(input logic [BF_EXP_W-1:0] exp);
    return exp == EXP_ALL_ONES;
  endfunction

endpackage

// File: rtl/bf16_pow2_scale_pipe_lane.sv
// One scaling lane: classify and exponent subtract into S1, resolve
// overflow/underflow/specials into S2. Stage advance is driven by the top.
module bf16_pow2_lane
  import bf16_pkg::*;
#(
  parameter int unsigned SHIFT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s1_load,
  input  logic               s2_load,
  input  bf16_t              in_elem,
  input  logic [SHIFT_W-1:0] in_shift,
  output bf16_t              out_elem,
  output logic               out_ovf,
  output logic               out_unf
);

  // Two guard bits keep e - shift exact over the full signed shift range.
  localparam int unsigned ENEW_W = BF_EXP_W + 2;
  localparam logic signed [ENEW_W-1:0] ENEW_MAX  = ENEW_W'(EXP_ALL_ONES);
  localparam logic signed [ENEW_W-1:0] ENEW_ZERO = '0;

  logic signed [ENEW_W-1:0] shift_ext;
  logic signed [ENEW_W-1:0] e_new_c;
  lane_class_t              cls_c;

  bf16_t                    s1_elem;
  lane_class_t              s1_cls;
  logic signed [ENEW_W-1:0] s1_enew;

  bf16_t                    res_c;
  logic                     ovf_c;
  logic                     unf_c;

  always_comb begin
    shift_ext = ENEW_W'(signed'(in_shift));
    e_new_c   = signed'({2'b00, in_elem.exp}) - shift_ext;
    if (in_elem.exp == '0)
      cls_c = CLS_ZERO;
    else if (is_special(in_elem.exp))
      cls_c = CLS_SPECIAL;
    else
      cls_c = CLS_NORMAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_elem <= '0;
      s1_cls  <= CLS_ZERO;
      s1_enew <= '0;
    end else if (s1_load) begin
      s1_elem <= in_elem;
      s1_cls  <= cls_c;
      s1_enew <= e_new_c;
    end
  end

  always_comb begin
    res_c = '{sign: s1_elem.sign, exp: '0, man: '0};
    ovf_c = 1'b0;
    unf_c = 1'b0;
    case (s1_cls)
      CLS_SPECIAL: res_c = s1_elem;
      CLS_NORMAL: begin
        if (s1_enew >= ENEW_MAX) begin
          res_c = s1_elem.sign ? NEG_INF : POS_INF;
          ovf_c = 1'b1;
        end else if (s1_enew <= ENEW_ZERO) begin
          unf_c = 1'b1;
        end else begin
          res_c = '{sign: s1_elem.sign, exp: s1_enew[BF_EXP_W-1:0], man: s1_elem.man};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_elem <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else if (s2_load) begin
      out_elem <= res_c;
      out_ovf  <= ovf_c;
      out_unf  <= unf_c;
    end
  end

endmodule

// File: rtl/bf16_pow2_scale_pipe.sv
// Multi-lane bfloat16 a*2^(-shift) scaler with a two-stage elastic
// valid/ready pipeline and a sticky overflow/underflow flag.
module bf16_pow2_scale_pipe
  import bf16_pkg::*;
#(
  parameter int unsigned LANES         = 4,
  parameter int unsigned EXP_SIZE      = BF_EXP_W,
  parameter int unsigned MANTISSA_SIZE = BF_MAN_W,
  parameter int unsigned SHIFT_W       = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [LANES*(1+EXP_SIZE+MANTISSA_SIZE)-1:0] in_data,
  input  logic [SHIFT_W-1:0]                          in_shift,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [LANES*(1+EXP_SIZE+MANTISSA_SIZE)-1:0] out_data,
  output logic [LANES-1:0]                            out_ovf,
  output logic [LANES-1:0]                            out_unf,
  output logic                                        err_sticky,
  input  logic                                        err_clr
);

  localparam int unsigned W = 1 + EXP_SIZE + MANTISSA_SIZE;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  // Ready ripples back combinationally so a full pipe still streams 1 beat/cycle.
  always_comb begin
    s2_adv   = out_ready || !s2_valid;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    s1_load  = in_valid && in_ready;
    s2_load  = s2_adv && s1_valid;
  end

  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= s1_load;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr)
      err_sticky <= 1'b0;
    else if (out_valid && out_ready && |(out_ovf | out_unf))
      err_sticky <= 1'b1;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bf16_pow2_lane #(
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .s1_load  (s1_load),
      .s2_load  (s2_load),
      .in_elem  (in_data[l*W +: W]),
      .in_shift (in_shift),
      .out_elem (out_data[l*W +: W]),
      .out_ovf  (out_ovf[l]),
      .out_unf  (out_unf[l])
    );
  end

endmodule

// File: tb/tb_bf16_pow2_scale_pipe.sv
// Directed bench for bf16_pow2_scale_pipe: scaling, boundaries, specials,
// backpressure, sticky error flag and mid-stream reset.
module tb_bf16_pow2_scale_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_ovf;
  logic [3:0]  out_unf;
  logic        err_sticky;
  logic        err_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf16_pow2_scale_pipe #(
    .LANES         (4),
    .EXP_SIZE      (8),
    .MANTISSA_SIZE (7),
    .SHIFT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shift   (in_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  function automatic logic [63:0] bp_beat(input int i);
    logic [15:0] k;
    k = 16'(i);
    return {16'h4400 + k, 16'h4300 + k, 16'hC200 + k, 16'h4100 + k};
  endfunction

  // Same lanes scaled by 2^-1: exponent field one lower.
  function automatic logic [63:0] bp_exp(input int i);
    logic [15:0] k;
    k = 16'(i);
    return {16'h4380 + k, 16'h4280 + k, 16'hC180 + k, 16'h4080 + k};
  endfunction

  task automatic cyc(input logic v, input logic [63:0] d, input logic [7:0] s);
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_shift = s;
  endtask

  // Drive one beat, idle two cycles, stop at the negedge where it is on the output.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] s);
    cyc(1'b1, d, s);
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_data !== 64'h0) begin n_err++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    n_cmp++; if (out_ovf !== 4'h0) begin n_err++; $display("FAIL rst_out_ovf got=%b want=0000", out_ovf); end
    n_cmp++; if (out_unf !== 4'h0) begin n_err++; $display("FAIL rst_out_unf got=%b want=0000", out_unf); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL rst_err_sticky got=%b want=0", err_sticky); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    cyc(1'b1, 64'h0000_0000_C040_3F80, 8'd1);
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency1 got=%b want=0", out_valid); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_data !== 64'h0000_0000_BFC0_3F00) begin n_err++; $display("FAIL basic_data got=%h want=0000_0000_bfc0_3f00", out_data); end
    n_cmp++; if ({out_ovf, out_unf} !== 8'h00) begin n_err++; $display("FAIL basic_flags got=%b/%b want=0000/0000", out_ovf, out_unf); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_single got=%b want=0", out_valid); end
  endtask

  task automatic test_neg_shift;
    out_ready = 1'b1;
    send_beat(64'h0000_0000_C040_3F80, 8'hFF);
    n_cmp++; if (out_data !== 64'h0000_0000_C0C0_4000) begin n_err++; $display("FAIL neg1_data got=%h want=0000_0000_c0c0_4000", out_data); end
    n_cmp++; if (out_ovf !== 4'b0000) begin n_err++; $display("FAIL neg1_ovf got=%b want=0000", out_ovf); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL neg1_sticky got=%b want=0", err_sticky); end
    send_beat(64'h0000_0000_C040_3F80, 8'h80);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL neg128_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_data !== 64'h0000_0000_FF80_7F80) begin n_err++; $display("FAIL neg128_data got=%h want=0000_0000_ff80_7f80", out_data); end
    n_cmp++; if (out_ovf !== 4'b0011) begin n_err++; $display("FAIL neg128_ovf got=%b want=0011", out_ovf); end
    n_cmp++; if (out_unf !== 4'b0000) begin n_err++; $display("FAIL neg128_unf got=%b want=0000", out_unf); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL neg128_sticky got=%b want=1", err_sticky); end
  endtask

  task automatic test_specials;
    out_ready = 1'b1;
    send_beat(64'h8000_0001_7FC0_3F80, 8'd127);
    n_cmp++; if (out_data !== 64'h8000_0000_7FC0_0000) begin n_err++; $display("FAIL spec_data got=%h want=8000_0000_7fc0_0000", out_data); end
    n_cmp++; if (out_unf !== 4'b0001) begin n_err++; $display("FAIL spec_unf got=%b want=0001", out_unf); end
    n_cmp++; if (out_ovf !== 4'b0000) begin n_err++; $display("FAIL spec_ovf got=%b want=0000", out_ovf); end
    send_beat(64'h7F7F_0080_C2F7_4049, 8'd0);
    n_cmp++; if (out_data !== 64'h7F7F_0080_C2F7_4049) begin n_err++; $display("FAIL ident_data got=%h want=7f7f_0080_c2f7_4049", out_data); end
    n_cmp++; if ({out_ovf, out_unf} !== 8'h00) begin n_err++; $display("FAIL ident_flags got=%b/%b want=0000/0000", out_ovf, out_unf); end
  endtask

  task automatic test_boundaries;
    out_ready = 1'b1;
    send_beat(64'hFF80_7F00_0100_0080, 8'd1);
    n_cmp++; if (out_data !== 64'hFF80_7E80_0080_0000) begin n_err++; $display("FAIL bnd_lo_data got=%h want=ff80_7e80_0080_0000", out_data); end
    n_cmp++; if (out_unf !== 4'b0001) begin n_err++; $display("FAIL bnd_lo_unf got=%b want=0001", out_unf); end
    n_cmp++; if (out_ovf !== 4'b0000) begin n_err++; $display("FAIL bnd_lo_ovf got=%b want=0000", out_ovf); end
    send_beat(64'h7F80_8080_7E80_7F00, 8'hFF);
    n_cmp++; if (out_data !== 64'h7F80_8100_7F00_7F80) begin n_err++; $display("FAIL bnd_hi_data got=%h want=7f80_8100_7f00_7f80", out_data); end
    n_cmp++; if (out_ovf !== 4'b0001) begin n_err++; $display("FAIL bnd_hi_ovf got=%b want=0001", out_ovf); end
    n_cmp++; if (out_unf !== 4'b0000) begin n_err++; $display("FAIL bnd_hi_unf got=%b want=0000", out_unf); end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(posedge clk); #1;
      in_valid  = (sent < 4);
      in_data   = bp_beat(sent);
      in_shift  = 8'd1;
      out_ready = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (c == 2 || c == 3) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== bp_exp(0)) begin n_err++; $display("FAIL bp_hold c=%0d got=%b/%h want=1/%h", c, out_valid, out_data, bp_exp(0)); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== bp_exp(got)) begin n_err++; $display("FAIL bp_order beat=%0d got=%h want=%h", got, out_data, bp_exp(got)); end
        got++;
      end
    end
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL bp_count got=%0d want=4", got); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_sticky_clear;
    out_ready = 1'b1;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL clr_alone got=%b want=0", err_sticky); end
    send_beat(64'h0000_0000_0000_7F00, 8'hFF);
    n_cmp++; if (out_valid !== 1'b1 || out_ovf !== 4'b0001) begin n_err++; $display("FAIL clr_beat got=%b/%b want=1/0001", out_valid, out_ovf); end
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL clr_wins got=%b want=0", err_sticky); end
    send_beat(64'h0000_0000_0000_7F00, 8'hFF);
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL clr_reset_again got=%b want=1", err_sticky); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    cyc(1'b1, bp_beat(0), 8'd1);
    cyc(1'b1, bp_beat(1), 8'd1);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = bp_beat(2); in_shift = 8'd1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_data !== 64'h0 || out_ovf !== 4'h0 || out_unf !== 4'h0) begin n_err++; $display("FAIL mrst_outs got=%h/%b/%b want=0/0000/0000", out_data, out_ovf, out_unf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL mrst_sticky got=%b want=0", err_sticky); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_discard got=%b want=0", out_valid); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== bp_exp(2)) begin n_err++; $display("FAIL mrst_new_beat got=%b/%h want=1/%h", out_valid, out_data, bp_exp(2)); end
    cyc(1'b0, '0, '0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_after got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_shift();
    test_specials();
    test_boundaries();
    test_backpressure();
    test_sticky_clear();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
